// File: rtl/mipi_bayer_pkg.sv
// rtl/mipi_bayer_pkg.sv - shared widths, row-type codes and RGB565 packing for the Bayer demosaic
package mipi_bayer_pkg;

  localparam int RAW_W        = 10;
  localparam int R_W          = 5;
  localparam int G_W          = 6;
  localparam int B_W          = 5;
  localparam int RGB_W        = R_W + G_W + B_W;
  localparam int PIX_PER_BEAT = 4;

  localparam logic ROW_GB = 1'b0;
  localparam logic ROW_RG = 1'b1;

  typedef struct packed {
    logic [RAW_W-1:0] r;
    logic [RAW_W-1:0] g;
    logic [RAW_W-1:0] b;
  } rgb10_t;

  // Plain truncation of each 10-bit channel to its RGB565 field.
  function automatic logic [RGB_W-1:0] pack_rgb565(input rgb10_t px);
    return {px.r[RAW_W-1 -: R_W], px.g[RAW_W-1 -: G_W], px.b[RAW_W-1 -: B_W]};
  endfunction

endpackage

// File: rtl/mipi_bayer_to_rgb_line_buf.sv
// rtl/mipi_bayer_to_rgb_line_buf.sv - one-line buffer, registered read, read-before-write
module bayer_line_buf #(
  parameter int Depth  = 480,
  parameter int Width  = 40,
  parameter int Addr_w = 9
) (
  input  logic              I_CLK,
  input  logic              wr_en,
  input  logic [Addr_w-1:0] wr_addr,
  input  logic [Width-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [Addr_w-1:0] rd_addr,
  output logic [Width-1:0]  rd_data
);

  logic [Width-1:0] mem [0:Depth-1];

  // Both updates are non-blocking, so a same-address read returns the old word.
  always_ff @(posedge I_CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/mipi_bayer_to_rgb.sv
// rtl/mipi_bayer_to_rgb.sv - GBRG RAW10 to RGB565 demosaic, 4 pixels per beat, 2-cycle latency
// Optional: define BAYER_GREEN_AVG_EN to average both G samples of a quad (else current-row G only).
module mipi_bayer_to_rgb
  import mipi_bayer_pkg::*;
#(
  parameter int Image_width = 1920,
  parameter int Image_Higth = 1080,
  parameter int Pixel_Num   = 4,
  parameter int Col_Max     = Image_width / Pixel_Num,
  parameter int I_w         = Pixel_Num * 10
) (
  input  logic           I_CLK,
  input  logic           I_Rst_n,
  input  logic           I_Mipi_Unpacket_V_sync,
  input  logic [I_w-1:0] I_Mipi_raw10_depacker_Data,
  input  logic           I_Mipi_raw10_depacker_Vaild,
  output logic           O_RGB_Vaild,
  output logic [63:0]    O_RGB_Data
);

  localparam int CW = (Col_Max > 1) ? $clog2(Col_Max) : 1;

  if (Pixel_Num != PIX_PER_BEAT || I_w != Pixel_Num * RAW_W || Image_Higth < 1) begin : g_cfg_err
    $error("mipi_bayer_to_rgb: unsupported geometry");
  end

  logic [CW-1:0]  col_cnt;
  logic           Pixel_flag;
  logic           first_line;
  logic           beat;

  logic           s1_valid;
  logic [I_w-1:0] s1_data;
  logic           s1_flag;
  logic           s1_first;
  logic [I_w-1:0] lb_rd_data;
  logic [I_w-1:0] prev_word;
  logic [63:0]    rgb_next;

  // Frame sync wins over a coincident beat, which is then dropped entirely.
  assign beat = I_Mipi_raw10_depacker_Vaild & ~I_Mipi_Unpacket_V_sync;

  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      col_cnt    <= '0;
      Pixel_flag <= ROW_GB;
      first_line <= 1'b1;
    end else if (I_Mipi_Unpacket_V_sync) begin
      col_cnt    <= '0;
      Pixel_flag <= ROW_GB;
      first_line <= 1'b1;
    end else if (beat) begin
      if (col_cnt == CW'(Col_Max - 1)) begin
        col_cnt    <= '0;
        Pixel_flag <= ~Pixel_flag;
        first_line <= 1'b0;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  bayer_line_buf #(
    .Depth  (Col_Max),
    .Width  (I_w),
    .Addr_w (CW)
  ) u_line_buf (
    .I_CLK   (I_CLK),
    .wr_en   (beat),
    .wr_addr (col_cnt),
    .wr_data (I_Mipi_raw10_depacker_Data),
    .rd_en   (beat),
    .rd_addr (col_cnt),
    .rd_data (lb_rd_data)
  );

  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_flag  <= ROW_GB;
      s1_first <= 1'b1;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_data  <= I_Mipi_raw10_depacker_Data;
        s1_flag  <= Pixel_flag;
        s1_first <= first_line;
      end
    end
  end

  assign prev_word = s1_first ? '0 : lb_rd_data;

  always_comb begin
    logic [RAW_W-1:0] c0, c1, p0, p1, g_cur, g_oth;
    logic [RAW_W:0]   g_sum;
    rgb10_t           px;
    logic [RGB_W-1:0] pix;
    rgb_next = '0;
    for (int q = 0; q < PIX_PER_BEAT / 2; q++) begin
      c0 = s1_data[(2*q)*RAW_W +: RAW_W];
      c1 = s1_data[(2*q+1)*RAW_W +: RAW_W];
      p0 = prev_word[(2*q)*RAW_W +: RAW_W];
      p1 = prev_word[(2*q+1)*RAW_W +: RAW_W];
      // G/B row sits under an R/G row and vice versa.
      if (s1_flag == ROW_GB) begin
        g_cur = c0;
        px.b  = c1;
        px.r  = p0;
        g_oth = p1;
      end else begin
        px.r  = c0;
        g_cur = c1;
        g_oth = p0;
        px.b  = p1;
      end
`ifdef BAYER_GREEN_AVG_EN
      g_sum = {1'b0, g_cur} + {1'b0, g_oth};
      px.g  = g_sum[RAW_W:1];
`else
      g_sum = '0;
      px.g  = g_cur;
`endif
      pix = pack_rgb565(px);
      rgb_next[(2*q)*RGB_W +: RGB_W]   = pix;
      rgb_next[(2*q+1)*RGB_W +: RGB_W] = pix;
    end
  end

  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      O_RGB_Vaild <= 1'b0;
      O_RGB_Data  <= '0;
    end else begin
      O_RGB_Vaild <= s1_valid;
      if (s1_valid) O_RGB_Data <= rgb_next;
    end
  end

endmodule

// File: tb/tb_mipi_bayer_to_rgb.sv
// tb/tb_mipi_bayer_to_rgb.sv - scoreboard bench for mipi_bayer_to_rgb (BAYER_GREEN_AVG_EN aware)
module tb_mipi_bayer_to_rgb;

`ifdef BAYER_GREEN_AVG_EN
  localparam bit AVG = 1'b1;
  localparam logic [63:0] EXP_GB_FIRST = 64'h021F_021F_021F_021F;
`else
  localparam bit AVG = 1'b0;
  localparam logic [63:0] EXP_GB_FIRST = 64'h041F_041F_041F_041F;
`endif
  localparam logic [63:0] EXP_RG_SECOND = 64'hFC1F_FC1F_FC1F_FC1F;
  localparam logic [39:0] WORD_GB = {10'h3FF, 10'h200, 10'h3FF, 10'h200};
  localparam logic [39:0] WORD_RG = {10'h200, 10'h3FF, 10'h200, 10'h3FF};
  localparam int COLS = 480;

  logic        I_CLK = 1'b0;
  logic        I_Rst_n = 1'b0;
  logic        I_Mipi_Unpacket_V_sync = 1'b0;
  logic [39:0] I_Mipi_raw10_depacker_Data = '0;
  logic        I_Mipi_raw10_depacker_Vaild = 1'b0;
  logic        O_RGB_Vaild;
  logic [63:0] O_RGB_Data;

  mipi_bayer_to_rgb dut (
    .I_CLK                       (I_CLK),
    .I_Rst_n                     (I_Rst_n),
    .I_Mipi_Unpacket_V_sync      (I_Mipi_Unpacket_V_sync),
    .I_Mipi_raw10_depacker_Data  (I_Mipi_raw10_depacker_Data),
    .I_Mipi_raw10_depacker_Vaild (I_Mipi_raw10_depacker_Vaild),
    .O_RGB_Vaild                 (O_RGB_Vaild),
    .O_RGB_Data                  (O_RGB_Data)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [63:0] d;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_push = 0;
  int          n_flush = 0;
  int          n_out = 0;
  logic [63:0] last_exp = '0;

  logic [9:0]  prev_row [0:COLS*4-1];
  int          m_col = 0;
  bit          m_odd = 1'b0;
  bit          m_first = 1'b1;

  always @(posedge I_CLK) cyc <= cyc + 1;

  // Bayer colour at (row parity, x): 0=R, 1=G, 2=B.
  function automatic int colour(input bit odd, input int x);
    if (!odd) return (x % 2 == 0) ? 1 : 2;
    return (x % 2 == 0) ? 0 : 1;
  endfunction

  task automatic model_reset();
    m_col = 0;
    m_odd = 1'b0;
    m_first = 1'b1;
  endtask

  task automatic model_step(input logic [39:0] d, output logic [63:0] e);
    int r, b, gc, go, g, x, v, pv, px;
    e = '0;
    for (int q = 0; q < 2; q++) begin
      r = 0; b = 0; gc = 0; go = 0;
      for (int k = 0; k < 2; k++) begin
        x = m_col * 4 + 2 * q + k;
        v = int'(d[(2*q+k)*10 +: 10]);
        case (colour(m_odd, x))
          0: r = v;
          2: b = v;
          default: gc = v;
        endcase
        pv = m_first ? 0 : int'(prev_row[x]);
        case (colour(!m_odd, x))
          0: r = pv;
          2: b = pv;
          default: go = pv;
        endcase
      end
      g = AVG ? (gc + go) / 2 : gc;
      px = ((r >> 5) << 11) | ((g >> 4) << 5) | (b >> 5);
      e[32*q +: 16]      = px[15:0];
      e[32*q + 16 +: 16] = px[15:0];
    end
    for (int k = 0; k < 4; k++) prev_row[m_col*4 + k] = d[k*10 +: 10];
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      m_odd = !m_odd;
      m_first = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called at posedge+2; returns at the next posedge+2.
  task automatic do_beat(input logic [39:0] d, input bit v, input bit vs,
                         input bit use_c, input logic [63:0] cexp);
    logic [63:0] m;
    exp_t        e;
    I_Mipi_raw10_depacker_Data  = d;
    I_Mipi_raw10_depacker_Vaild = v;
    I_Mipi_Unpacket_V_sync      = vs;
    if (vs) begin
      model_reset();
    end else if (v) begin
      model_step(d, m);
      e.d = use_c ? cexp : m;
      e.c = cyc;
      sb.push_back(e);
      n_push++;
    end
    @(posedge I_CLK);
    #2;
    I_Mipi_raw10_depacker_Vaild = 1'b0;
    I_Mipi_Unpacket_V_sync      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_beat('0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [39:0] rnd_word();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    return r64[39:0];
  endfunction

  task automatic random_beats(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, max_gap));
      do_beat(rnd_word(), 1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  always @(negedge I_CLK) begin
    exp_t e;
    if (I_Rst_n) begin
      if (O_RGB_Vaild) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, required no output", O_RGB_Data);
        end else begin
          e = sb.pop_front();
          n_out++;
          check("rgb_data", O_RGB_Data, e.d);
          check("latency", 64'(cyc - e.c), 64'd2);
          last_exp = e.d;
        end
      end else begin
        check("hold_data", O_RGB_Data, last_exp);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge I_CLK);
    #2;
    check("reset_valid", 64'(O_RGB_Vaild), 64'd0);
    check("reset_data", O_RGB_Data, 64'h0);
    check("reset_flag", 64'(dut.Pixel_flag), 64'd0);
    I_Rst_n = 1'b1;
    idle(2);

    do_beat('0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < COLS; i++) do_beat(WORD_GB, 1'b1, 1'b0, 1'b1, EXP_GB_FIRST);
    check("flag_after_line1", 64'(dut.Pixel_flag), 64'(m_odd));
    for (int i = 0; i < COLS; i++) do_beat(WORD_RG, 1'b1, 1'b0, 1'b1, EXP_RG_SECOND);
    check("flag_after_line2", 64'(dut.Pixel_flag), 64'(m_odd));

    for (int i = 0; i < COLS; i++) begin
      idle($urandom_range(0, 2));
      if (i == COLS - 1) check("flag_before_last", 64'(dut.Pixel_flag), 64'(m_odd));
      do_beat(rnd_word(), 1'b1, 1'b0, 1'b0, '0);
    end
    check("flag_after_last", 64'(dut.Pixel_flag), 64'(m_odd));
    idle(4);
    check("out_count_gaps", 64'(n_out), 64'(n_push));

    random_beats(100, 1);
    do_beat(rnd_word(), 1'b1, 1'b1, 1'b0, '0);
    idle(3);
    check("flag_after_vsync", 64'(dut.Pixel_flag), 64'd0);
    random_beats(COLS, 1);
    check("flag_vsync_line1", 64'(dut.Pixel_flag), 64'(m_odd));
    random_beats(COLS, 1);

    random_beats(50, 1);
    I_Rst_n = 1'b0;
    #1;
    check("midreset_valid", 64'(O_RGB_Vaild), 64'd0);
    check("midreset_data", O_RGB_Data, 64'h0);
    check("midreset_flag", 64'(dut.Pixel_flag), 64'd0);
    n_flush += sb.size();
    sb.delete();
    last_exp = '0;
    model_reset();
    @(posedge I_CLK);
    @(posedge I_CLK);
    #2;
    I_Rst_n = 1'b1;
    for (int i = 0; i < COLS; i++) do_beat(WORD_GB, 1'b1, 1'b0, 1'b1, EXP_GB_FIRST);
    check("flag_after_recovery", 64'(dut.Pixel_flag), 64'(m_odd));
    random_beats(40, 2);

    idle(6);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("out_count_total", 64'(n_out), 64'(n_push - n_flush));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
